gen_nco_clk: RTL and testbench



---
 rtl/gen_nco_clk_pkg.sv | 28 ++
 rtl/gen_nco_clk_if.sv | 22 ++
 rtl/gen_nco_clk_channel.sv | 95 +++++++++
 rtl/gen_nco_clk.sv | 59 +++++
 tb/tb_gen_nco_clk.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/gen_nco_clk_pkg.sv
// rtl/gen_nco_clk_pkg.sv - shared constants and increment lookup for the NCO clock generator
//
// Purpose: default accumulator width and the four standard colour-clock increments
// for a 29-bit accumulator, plus a helper that selects one of them.
//   inc_for(altern, mode):
//     altern 0 = 140 MHz system clock, 1 = 170 MHz system clock
//     mode   0 = PAL 4x subcarrier,    1 = NTSC 4x subcarrier
package gen_nco_pkg;

  localparam int DEF_ACC_W = 29;

  localparam logic [DEF_ACC_W-1:0] INC_PAL_140  = 29'd68008027;
  localparam logic [DEF_ACC_W-1:0] INC_NTSC_140 = 29'd54907245;
  localparam logic [DEF_ACC_W-1:0] INC_PAL_170  = 29'd56006610;
  localparam logic [DEF_ACC_W-1:0] INC_NTSC_170 = 29'd45217732;

  function automatic logic [DEF_ACC_W-1:0] inc_for(input logic altern, input logic mode);
    logic [DEF_ACC_W-1:0] r;
    case ({altern, mode})
      2'b00:   r = INC_PAL_140;
      2'b01:   r = INC_NTSC_140;
      2'b10:   r = INC_PAL_170;
      default: r = INC_NTSC_170;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gen_nco_clk_if.sv
// rtl/gen_nco_clk_if.sv - increment register write port of the NCO clock generator
//
// Purpose: groups the increment write strobe, channel select, data and the
// per-channel busy (increment pending) flags.
//   wr_en   : increment write strobe
//   wr_ch   : target channel (writes to channels >= NCH are dropped)
//   wr_data : new increment
//   busy    : per-channel pending increment not yet applied
// Modports: master drives the writes, slave is the generator.
interface gen_nco_clk_if #(
  parameter int ACC_W = 29,
  parameter int NCH   = 2,
  parameter int CH_W  = 1
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [ACC_W-1:0] wr_data;
  logic [NCH-1:0]   busy;

  modport master (output wr_en, output wr_ch, output wr_data, input busy);
  modport slave  (input wr_en, input wr_ch, input wr_data, output busy);
endinterface

// File: rtl/gen_nco_clk_channel.sv
// rtl/gen_nco_clk_channel.sv - one phase-accumulator channel with wrap-synchronous increment update
//
// Purpose: accumulates inc_act each enabled cycle, flags carry-out as tick and
// swaps in a pending increment only at a wrap (or at once while stopped).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en, sync   : run enable, phase realign strobe (sync has priority)
//   wr, wr_data: increment write for this channel
//   busy       : pending increment not yet applied
//   clk_out    : acc MSB
//   clk_q      : acc MSB ^ acc MSB-1 (quadrature)
//   tick       : one-cycle pulse after a wrapping addition
//   phase      : top PH_W bits of acc
module nco_channel #(
  parameter int               ACC_W     = 29,
  parameter int               PH_W      = 8,
  parameter logic [ACC_W-1:0] RESET_INC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_data,
  output logic             busy,
  output logic             clk_out,
  output logic             clk_q,
  output logic             tick,
  output logic [PH_W-1:0]  phase
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_act_q, inc_act_d;
  logic [ACC_W-1:0] inc_pend_q, inc_pend_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, inc_act_q};

  always_comb begin
    acc_d      = acc_q;
    inc_act_d  = inc_act_q;
    inc_pend_d = inc_pend_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;

    if (sync) begin
      // Realign only; a pending increment waits for a genuine wrap.
      acc_d = '0;
    end else if (!en) begin
      // Stopped: no output edge can be disturbed, so apply right away.
      if (pend_q) begin
        inc_act_d = inc_pend_q;
        pend_d    = 1'b0;
      end
    end else begin
      acc_d  = sum[ACC_W-1:0];
      tick_d = sum[ACC_W];
      if (sum[ACC_W] && pend_q) begin
        inc_act_d = inc_pend_q;
        pend_d    = 1'b0;
      end
    end

    // A write in the same cycle as an apply re-arms pend with the newer value.
    if (wr) begin
      inc_pend_d = wr_data;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      inc_act_q  <= RESET_INC;
      inc_pend_q <= '0;
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_act_q  <= inc_act_d;
      inc_pend_q <= inc_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
    end
  end

  assign busy    = pend_q;
  assign tick    = tick_q;
  assign clk_out = acc_q[ACC_W-1];
  assign clk_q   = acc_q[ACC_W-1] ^ acc_q[ACC_W-2];
  assign phase   = acc_q[ACC_W-1 -: PH_W];

endmodule

// File: rtl/gen_nco_clk.sv
// rtl/gen_nco_clk.sv - multi-channel programmable phase-accumulator clock generator
//
// Purpose: NCH independent NCO channels producing square, quadrature, wrap tick
// and phase outputs from one fast clock; increments written through wr.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (release synchronised externally)
//   en, sync   : per-channel run enable and phase realign strobe
//   wr         : increment write port (wr_en/wr_ch/wr_data in, busy out)
//   clk_out    : per-channel square wave
//   clk_q      : per-channel quadrature wave
//   tick       : per-channel wrap pulse
//   phase      : channel k at bits [k*PH_W +: PH_W]
module gen_nco_clk import gen_nco_pkg::*; #(
  parameter int               ACC_W     = DEF_ACC_W,
  parameter int               NCH       = 2,
  parameter int               CH_W      = 1,
  parameter int               PH_W      = 8,
  parameter logic [ACC_W-1:0] RESET_INC = ACC_W'(INC_PAL_140)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      en,
  input  logic [NCH-1:0]      sync,
  gen_nco_clk_if.slave        wr,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      clk_q,
  output logic [NCH-1:0]      tick,
  output logic [NCH*PH_W-1:0] phase
);

  logic [NCH-1:0] busy_w;
  logic [NCH-1:0] wr_sel;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    // Only existing channel indices can match, so wr_ch >= NCH is dropped.
    assign wr_sel[k] = wr.wr_en && (wr.wr_ch == CH_W'(k));

    nco_channel #(
      .ACC_W     (ACC_W),
      .PH_W      (PH_W),
      .RESET_INC (RESET_INC)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en[k]),
      .sync    (sync[k]),
      .wr      (wr_sel[k]),
      .wr_data (wr.wr_data),
      .busy    (busy_w[k]),
      .clk_out (clk_out[k]),
      .clk_q   (clk_q[k]),
      .tick    (tick[k]),
      .phase   (phase[k*PH_W +: PH_W])
    );
  end

  assign wr.busy = busy_w;

endmodule

// File: tb/tb_gen_nco_clk.sv
// tb/tb_gen_nco_clk.sv - table-driven self-checking bench for gen_nco_clk
module tb_gen_nco_clk;

  localparam int ACC_W = 8;
  localparam int NCH   = 2;
  localparam int CH_W  = 2;
  localparam int PH_W  = 8;

  typedef struct {
    logic [1:0] en;
    logic [1:0] sync;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic [7:0] ph0;
    logic [7:0] ph1;
    logic [1:0] tick;
    logic [1:0] busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  en = '0;
  logic [1:0]  sync = '0;
  logic [1:0]  clk_out, clk_q, tick;
  logic [15:0] phase;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  gen_nco_clk_if #(.ACC_W(ACC_W), .NCH(NCH), .CH_W(CH_W)) wr_if ();

  gen_nco_clk #(
    .ACC_W(ACC_W), .NCH(NCH), .CH_W(CH_W), .PH_W(PH_W), .RESET_INC(8'd64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr(wr_if.slave),
    .clk_out(clk_out), .clk_q(clk_q), .tick(tick), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] e, input logic [1:0] s, input logic w, input logic [1:0] ch,
                     input logic [7:0] d, input logic [7:0] p0, input logic [7:0] p1,
                     input logic [1:0] t, input logic [1:0] b);
    vec_t v;
    v.en = e; v.sync = s; v.wr_en = w; v.wr_ch = ch; v.wr_data = d;
    v.ph0 = p0; v.ph1 = p1; v.tick = t; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                               input logic [1:0] t, input logic [1:0] b);
    chk({tag, " phase"}, phase, {p1, p0});
    chk({tag, " tick"}, {14'd0, tick}, {14'd0, t});
    chk({tag, " busy"}, {14'd0, wr_if.busy}, {14'd0, b});
    chk({tag, " clk_out"}, {14'd0, clk_out}, {14'd0, p1[7], p0[7]});
    chk({tag, " clk_q"}, {14'd0, clk_q}, {14'd0, p1[7] ^ p1[6], p0[7] ^ p0[6]});
  endtask

  initial begin
    // Free run at inc 64: tick every 4
    add(2'b11, 2'b00, 0, 0, 0,    64,  64, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   128, 128, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   192, 192, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,     0,   0, 2'b11, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    64,  64, 2'b00, 2'b00);
    // Write ch0 inc=32 at acc=64: applied at next wrap
    add(2'b11, 2'b00, 1, 0, 32,  128, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   192, 192, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,     0,   0, 2'b11, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    32,  64, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    64, 128, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    96, 192, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   128,   0, 2'b10, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   160,  64, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   192, 128, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   224, 192, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,     0,   0, 2'b11, 2'b00);
    // Write ch1 inc=128 while disabled: applied after 1 clk
    add(2'b01, 2'b00, 1, 1, 128,  32,   0, 2'b00, 2'b10);
    add(2'b01, 2'b00, 0, 0, 0,    64,   0, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    96, 128, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   128,   0, 2'b10, 2'b00);
    // Pending ch0 write, then sync at acc=192
    add(2'b11, 2'b00, 1, 0, 64,  160, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   192,   0, 2'b10, 2'b01);
    add(2'b11, 2'b01, 0, 0, 0,     0, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,    32,   0, 2'b10, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,    64, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,    96,   0, 2'b10, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   128, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   160,   0, 2'b10, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   192, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   224,   0, 2'b10, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,     0, 128, 2'b01, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    64,   0, 2'b10, 2'b00);
    // Two writes (16 then 96), then an out-of-range write
    add(2'b11, 2'b00, 1, 0, 16,  128, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 1, 0, 96,  192,   0, 2'b10, 2'b01);
    add(2'b11, 2'b00, 1, 3, 200,   0, 128, 2'b01, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    96,   0, 2'b10, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   192, 128, 2'b00, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    32,   0, 2'b11, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,   128, 128, 2'b00, 2'b00);
    // Write coinciding with an apply: old pend (64) applied, new (32) stays pending
    add(2'b11, 2'b00, 1, 0, 64,  224,   0, 2'b10, 2'b01);
    add(2'b11, 2'b00, 1, 0, 32,   64, 128, 2'b01, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   128,   0, 2'b10, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,   192, 128, 2'b00, 2'b01);
    add(2'b11, 2'b00, 0, 0, 0,     0,   0, 2'b11, 2'b00);
    add(2'b11, 2'b00, 0, 0, 0,    32, 128, 2'b00, 2'b00);

    wr_if.wr_en = 1'b0;
    wr_if.wr_ch = '0;
    wr_if.wr_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 8'd0, 8'd0, 2'b00, 2'b00);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      en = vecs[i].en;
      sync = vecs[i].sync;
      wr_if.wr_en = vecs[i].wr_en;
      wr_if.wr_ch = vecs[i].wr_ch;
      wr_if.wr_data = vecs[i].wr_data;
      @(posedge clk);
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].ph0, vecs[i].ph1, vecs[i].tick, vecs[i].busy);
    end

    // Asynchronous reset between edges with a pending write outstanding
    wr_if.wr_en = 1'b1;
    wr_if.wr_ch = 2'd0;
    wr_if.wr_data = 8'd200;
    @(posedge clk);
    #1;
    wr_if.wr_en = 1'b0;
    chk("pre_reset busy", {14'd0, wr_if.busy}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 8'd0, 8'd0, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    check_outputs("held_reset", 8'd0, 8'd0, 2'b00, 2'b00);
    rst_n = 1'b1;

    // Increment back at 64 on both channels, pending write lost
    for (int c = 1; c <= 8; c++) begin
      logic [7:0] p;
      p = 8'((c % 4) * 64);
      @(posedge clk);
      #1;
      check_outputs($sformatf("post_reset%0d", c), p, p, (c % 4 == 0) ? 2'b11 : 2'b00, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
